pipe_stall_ctrl: RTL

//  Pipeline hazard/stall controller for the 5-stage MIPS core: the producer side of the stall/bubble

---
 rtl/pipe_ctrl_pkg.sv | 16 +
 rtl/pipe_stall_ctrl_mem_wait_timer.sv | 35 +++
 rtl/pipe_stall_ctrl.sv | 135 +++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and constants for the pipeline stall controller
package pipe_ctrl_pkg;

  // Controller state: free-running pipe or frozen on an outstanding data-memory access
  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  // Architectural $zero never creates a load-use dependency
  localparam logic [4:0] REG_ZERO = 5'd0;

  // Default number of MEM_WAIT cycles tolerated before flagging a timeout
  localparam int TIMEOUT_CYC_DEF = 255;

endpackage

// File: rtl/pipe_stall_ctrl_mem_wait_timer.sv
// rtl/pipe_stall_ctrl_mem_wait_timer.sv - saturating MEM_WAIT cycle counter with sticky timeout flag
module mem_wait_timer #(
  parameter int TIMEOUT_CYC = 255,
  parameter int TMO_W       = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear,
  input  logic enable,
  output logic timeout
);

  localparam logic [TMO_W-1:0] CNT_MAX  = '1;
  localparam logic [TMO_W-1:0] CNT_LAST = TMO_W'(TIMEOUT_CYC - 1);

  logic [TMO_W-1:0] cnt;

  // Count wait cycles (saturating); the flag latches once the limit is reached and holds until reset
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      cnt     <= '0;
      timeout <= 1'b0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      if (cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end
      if (cnt == CNT_LAST) begin
        timeout <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// rtl/pipe_stall_ctrl.sv - load-use / memory-wait stall and flush controller (optional PIPE_STALL_PERF_EN)
module pipe_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int TMO_W       = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        idex_memRead_i,
  input  logic [4:0]  idex_rt_i,
  input  logic [4:0]  ifid_rs_i,
  input  logic [4:0]  ifid_rt_i,
  input  logic        branch_taken_i,
  input  logic        dmem_req_i,
  input  logic        dmem_ack_i,
  output logic        pc_write_o,
  output logic        ifid_write_o,
  output logic        ifid_flush_o,
  output logic        idex_stall_o,
  output logic        idex_bubble_o,
  output logic        exmem_stall_o,
  output logic        memwb_bubble_o,
  output logic        busy_o,
  output logic        timeout_o,
  output logic [31:0] stall_cycles_o
);

  state_t state, state_next;
  logic   flush_pend;
  logic   mem_stall;
  logic   load_use;
  logic   access_start;

  // State register; reset abandons any outstanding access
  always_ff @(posedge clk_i) begin
    if (!rst_i) state <= RUN;
    else        state <= state_next;
  end

  // Next state and hazard outputs; reset forces a bubbled, non-advancing pipe
  always_comb begin
    state_next     = state;
    mem_stall      = 1'b0;
    load_use       = 1'b0;
    access_start   = 1'b0;
    pc_write_o     = 1'b1;
    ifid_write_o   = 1'b1;
    ifid_flush_o   = 1'b0;
    idex_stall_o   = 1'b0;
    idex_bubble_o  = 1'b0;
    exmem_stall_o  = 1'b0;
    memwb_bubble_o = 1'b0;
    busy_o         = (state == MEM_WAIT);

    case (state)
      RUN: begin
        if (dmem_req_i && !dmem_ack_i) begin
          mem_stall    = 1'b1;
          access_start = 1'b1;
          state_next   = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        if (dmem_ack_i) state_next = RUN;
        else            mem_stall  = 1'b1;
      end
      default: state_next = RUN;
    endcase

    load_use = !mem_stall && idex_memRead_i && (idex_rt_i != REG_ZERO) &&
               ((idex_rt_i == ifid_rs_i) || (idex_rt_i == ifid_rt_i));

    if (mem_stall) begin
      pc_write_o     = 1'b0;
      ifid_write_o   = 1'b0;
      idex_stall_o   = 1'b1;
      exmem_stall_o  = 1'b1;
      memwb_bubble_o = 1'b1;
    end else if (load_use) begin
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      idex_bubble_o = 1'b1;
    end else begin
      ifid_flush_o = branch_taken_i || flush_pend;
    end

    if (!rst_i) begin
      pc_write_o     = 1'b0;
      ifid_write_o   = 1'b0;
      ifid_flush_o   = 1'b1;
      idex_stall_o   = 1'b0;
      idex_bubble_o  = 1'b1;
      exmem_stall_o  = 1'b0;
      memwb_bubble_o = 1'b1;
      busy_o         = 1'b0;
    end
  end

  // Remember a taken branch seen while frozen so it flushes IF/ID on the first free cycle
  always_ff @(posedge clk_i) begin
    if (!rst_i)                           flush_pend <= 1'b0;
    else if (mem_stall && branch_taken_i) flush_pend <= 1'b1;
    else if (ifid_flush_o)                flush_pend <= 1'b0;
  end

  mem_wait_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .TMO_W      (TMO_W)
  ) u_timer (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clear  (access_start),
    .enable (state == MEM_WAIT),
    .timeout(timeout_o)
  );

`ifdef PIPE_STALL_PERF_EN
  logic [31:0] perf_cnt;

  // Count cycles in which the PC is held, saturating at all-ones
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      perf_cnt <= 32'd0;
    end else if (!pc_write_o && (perf_cnt != 32'hFFFF_FFFF)) begin
      perf_cnt <= perf_cnt + 32'd1;
    end
  end

  assign stall_cycles_o = perf_cnt;
`else
  assign stall_cycles_o = 32'd0;
`endif

endmodule
